// File: rtl/pwm_seq_scheduler.sv
// pwm_seq_scheduler: fires pattern channels one at a time in ascending order.
// A latched channel mask, inter-channel gap and pass count are taken on start.
// Each channel's busy flag marks when it has finished. A channel whose busy never
// rises is abandoned after a fixed number of cycles.
module pwm_seq_scheduler #(
  parameter int unsigned _NUM_CHANNELS = 4,
  parameter int unsigned _GAP_WIDTH    = 16,
  parameter int unsigned _TIMEOUT      = 255
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [_NUM_CHANNELS-1:0] ch_mask,
  input  logic [_GAP_WIDTH-1:0]    gap_cycles,
  input  logic [7:0]               loop_num,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  output logic [_NUM_CHANNELS-1:0] pwm_en,
  output logic [7:0]               cur_ch,
  output logic [7:0]               loop_cnt,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic                     timeout_err
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitBusy = 3'd1;
  localparam logic [2:0] StRun      = 3'd2;
  localparam logic [2:0] StGap      = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  // Timer counts from 0, so the last allowed WAIT_BUSY cycle sees TIMEOUT-1.
  localparam logic [15:0]           TimerLast = 16'(_TIMEOUT - 1);
  localparam logic [_GAP_WIDTH-1:0] GapOne    = _GAP_WIDTH'(1);

  logic [2:0]               state_q, state_d;
  logic [_NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [_GAP_WIDTH-1:0]    gap_len_q, gap_len_d;
  logic [_GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]               loop_num_q, loop_num_d;
  logic [15:0]              timer_q, timer_d;
  logic [_NUM_CHANNELS-1:0] pwm_en_q, pwm_en_d;
  logic [7:0]               cur_ch_q, cur_ch_d;
  logic [7:0]               loop_cnt_q, loop_cnt_d;
  logic                     seq_busy_q, seq_busy_d;
  logic                     seq_done_q, seq_done_d;
  logic                     timeout_err_q, timeout_err_d;

  logic                     nxt_found;
  logic [7:0]               nxt_idx;
  logic                     busy_sel;

  function automatic logic [_NUM_CHANNELS-1:0] ch_onehot(input logic [7:0] idx);
    logic [_NUM_CHANNELS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(_NUM_CHANNELS); i++) begin
      oh[i] = (idx == 8'(i));
    end
    return oh;
  endfunction

  function automatic logic [7:0] lowest_ch(input logic [_NUM_CHANNELS-1:0] m);
    logic [7:0] idx;
    idx = '0;
    for (int i = int'(_NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (m[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  // Next set mask bit above the current channel; nxt_found low means the pass wraps.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = int'(_NUM_CHANNELS) - 1; i >= 0; i--) begin
      if (mask_q[i] && (8'(i) > cur_ch_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = 8'(i);
      end
    end
  end

  // Busy of the selected channel only; other channels' busy bits are ignored.
  always_comb begin
    busy_sel = |(pwm_busy & ch_onehot(cur_ch_q));
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    gap_len_d     = gap_len_q;
    gap_cnt_d     = gap_cnt_q;
    loop_num_d    = loop_num_q;
    timer_d       = timer_q;
    pwm_en_d      = pwm_en_q;
    cur_ch_d      = cur_ch_q;
    loop_cnt_d    = loop_cnt_q;
    seq_busy_d    = seq_busy_q;
    seq_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;

    if (stop && (state_q != StIdle)) begin
      // Abort: counters and the error flag are kept for inspection.
      state_d    = StIdle;
      pwm_en_d   = '0;
      seq_busy_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            mask_d        = ch_mask;
            gap_len_d     = gap_cycles;
            loop_num_d    = loop_num;
            loop_cnt_d    = '0;
            timeout_err_d = 1'b0;
            if (|ch_mask) begin
              state_d    = StWaitBusy;
              cur_ch_d   = lowest_ch(ch_mask);
              pwm_en_d   = ch_onehot(lowest_ch(ch_mask));
              timer_d    = '0;
              seq_busy_d = 1'b1;
            end else begin
              state_d    = StDone;
              seq_done_d = 1'b1;
              seq_busy_d = 1'b0;
            end
          end
        end
        StWaitBusy: begin
          if (busy_sel) begin
            state_d = StRun;
          end else if (timer_q == TimerLast) begin
            timeout_err_d = 1'b1;
            pwm_en_d      = '0;
            gap_cnt_d     = gap_len_q;
            state_d       = StGap;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        StRun: begin
          if (!busy_sel) begin
            pwm_en_d  = '0;
            gap_cnt_d = gap_len_q;
            state_d   = StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GapOne;
          end else if (nxt_found) begin
            state_d  = StWaitBusy;
            cur_ch_d = nxt_idx;
            pwm_en_d = ch_onehot(nxt_idx);
            timer_d  = '0;
          end else begin
            // Pass complete; loop_num of 0 runs forever with loop_cnt wrapping.
            loop_cnt_d = loop_cnt_q + 8'd1;
            if ((loop_num_q != 8'd0) && (loop_cnt_d == loop_num_q)) begin
              state_d    = StDone;
              seq_done_d = 1'b1;
              seq_busy_d = 1'b0;
            end else begin
              state_d  = StWaitBusy;
              cur_ch_d = lowest_ch(mask_q);
              pwm_en_d = ch_onehot(lowest_ch(mask_q));
              timer_d  = '0;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d    = StIdle;
          pwm_en_d   = '0;
          seq_busy_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      mask_q        <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      loop_num_q    <= '0;
      timer_q       <= '0;
      pwm_en_q      <= '0;
      cur_ch_q      <= '0;
      loop_cnt_q    <= '0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      loop_num_q    <= loop_num_d;
      timer_q       <= timer_d;
      pwm_en_q      <= pwm_en_d;
      cur_ch_q      <= cur_ch_d;
      loop_cnt_q    <= loop_cnt_d;
      seq_busy_q    <= seq_busy_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pwm_en      = pwm_en_q;
  assign cur_ch      = cur_ch_q;
  assign loop_cnt    = loop_cnt_q;
  assign seq_busy    = seq_busy_q;
  assign seq_done    = seq_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pwm_seq_scheduler.sv
// Testbench for pwm_seq_scheduler: table vectors, random scenarios checked against an
// arithmetic timeline model, plus hand-written stop / wrap / reset sequences.
module tb_pwm_seq_scheduler;

  localparam int Nch   = 4;
  localparam int Tmo   = 255;
  localparam int Never = 9999;

  typedef struct packed {
    logic [3:0]       mask;
    logic [15:0]      gap;
    logic [7:0]       loops;
    logic [3:0][15:0] dly;
    logic [15:0]      len;
    logic [7:0]       exp_en;
    logic [7:0]       exp_lc;
    logic             exp_tmo;
    logic             noise;
  } vec_t;

  typedef struct packed {
    int   ch;
    int   rise;
    int   fall;
    logic tmo;
  } ev_t;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic [15:0] gap_cycles = '0;
  logic [7:0]  loop_num = '0;
  logic [3:0]  pwm_busy = '0;
  logic [3:0]  pwm_en;
  logic [7:0]  cur_ch;
  logic [7:0]  loop_cnt;
  logic        seq_busy;
  logic        seq_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  done_q[$];
  int  exp_done;
  int  exp_lc;
  logic exp_tmo;

  int               rise[Nch];
  bit               rise_v[Nch];
  logic [3:0]       prev_en = '0;
  logic [3:0][15:0] dly_cfg = '0;
  logic [15:0]      len_cfg = 16'd1;
  logic             noise_en = 1'b0;

  bit track_lc = 1'b0;
  int lc_t0 = 0;
  int rise_cnt = 0;
  int lc_viol = 0;

  vec_t tbl[6];

  always #10 clk_50M = ~clk_50M;

  pwm_seq_scheduler #(
    ._NUM_CHANNELS(4),
    ._GAP_WIDTH   (16),
    ._TIMEOUT     (255)
  ) dut (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .ch_mask    (ch_mask),
    .gap_cycles (gap_cycles),
    .loop_num   (loop_num),
    .pwm_busy   (pwm_busy),
    .pwm_en     (pwm_en),
    .cur_ch     (cur_ch),
    .loop_cnt   (loop_cnt),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .timeout_err(timeout_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] m, input int g, input int lp, input int d3,
                              input int d2, input int d1, input int d0, input int ln,
                              input int een, input int elc, input logic etmo, input logic nz);
    vec_t v;
    v.mask    = m;
    v.gap     = 16'(g);
    v.loops   = 8'(lp);
    v.dly     = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    v.len     = 16'(ln);
    v.exp_en  = 8'(een);
    v.exp_lc  = 8'(elc);
    v.exp_tmo = etmo;
    v.noise   = nz;
    return v;
  endfunction

  // One clock: sample outputs 1 time unit after the edge, monitor, then drive busy.
  task automatic tick();
    int   age;
    ev_t  e;
    logic [3:0] busy_nx;
    @(posedge clk_50M);
    cyc++;
    #1;
    if ($countones(pwm_en) > 1) viol++;
    if (pwm_en != '0) begin
      if (!seq_busy || cur_ch >= 8'd4) viol++;
      else if (!pwm_en[cur_ch[1:0]]) viol++;
    end
    if (seq_done && seq_busy) viol++;
    if (seq_done) done_q.push_back(cyc);
    for (int ch = 0; ch < Nch; ch++) begin
      if (pwm_en[ch] && !prev_en[ch]) begin
        rise[ch]   = cyc;
        rise_v[ch] = 1'b1;
        if (track_lc) begin
          if (cyc != lc_t0 + 1 + 3 * rise_cnt) lc_viol++;
          if (loop_cnt != 8'(rise_cnt % 256)) lc_viol++;
          rise_cnt++;
        end
      end
      if (!pwm_en[ch] && prev_en[ch]) begin
        e.ch   = ch;
        e.rise = rise[ch];
        e.fall = cyc;
        e.tmo  = timeout_err;
        obs_q.push_back(e);
      end
    end
    prev_en = pwm_en;
    for (int ch = 0; ch < Nch; ch++) begin
      age = cyc - rise[ch];
      busy_nx[ch] = rise_v[ch] && (age >= int'(dly_cfg[ch])) &&
                    (age < int'(dly_cfg[ch]) + int'(len_cfg));
      if (noise_en && !pwm_en[ch] && ($urandom_range(0, 1) == 1)) busy_nx[ch] = 1'b1;
    end
    pwm_busy = busy_nx;
  endtask

  // Expected enable windows from the scheduling rules: enable at t, busy seen at t+dly,
  // enable falls one cycle after busy drops (or after Tmo cycles), next enable gap+1 later.
  task automatic model(input vec_t v, input int t0);
    int   t;
    int   f;
    logic acc;
    ev_t  e;
    exp_q.delete();
    t   = t0 + 1;
    acc = 1'b0;
    for (int p = 0; p < int'(v.loops); p++) begin
      for (int ch = 0; ch < Nch; ch++) begin
        if (v.mask[ch]) begin
          if (int'(v.dly[ch]) < Tmo) begin
            f = t + int'(v.dly[ch]) + int'(v.len) + 1;
          end else begin
            f   = t + Tmo;
            acc = 1'b1;
          end
          e.ch   = ch;
          e.rise = t;
          e.fall = f;
          e.tmo  = acc;
          exp_q.push_back(e);
          t = f + int'(v.gap) + 1;
        end
      end
    end
    exp_done = t;
    exp_lc   = (v.mask == 4'd0) ? 0 : int'(v.loops);
    exp_tmo  = acc;
  endtask

  task automatic start_seq(input vec_t v);
    dly_cfg  = v.dly;
    len_cfg  = v.len;
    noise_en = v.noise;
    tick();
    ch_mask    = v.mask;
    gap_cycles = v.gap;
    loop_num   = v.loops;
    start      = 1'b1;
    obs_q.delete();
    done_q.delete();
    viol = 0;
    model(v, cyc);
    tick();
    start = 1'b0;
  endtask

  task automatic finish_seq(input vec_t v, input int sid, input bit is_tbl);
    int n;
    int lim;
    n   = 0;
    lim = exp_done - cyc + 50;
    while (done_q.size() == 0 && n < lim) begin
      if (v.noise) begin
        ch_mask    = 4'($urandom);
        gap_cycles = 16'($urandom);
        loop_num   = 8'($urandom);
        start      = seq_busy && ($urandom_range(0, 3) == 0);
      end
      tick();
      n++;
    end
    start = 1'b0;
    repeat (4) tick();
    check($sformatf("s%0d_done_count", sid), done_q.size(), 1);
    if (done_q.size() > 0) check($sformatf("s%0d_done_cycle", sid), done_q[0], exp_done);
    check($sformatf("s%0d_n_enables", sid), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("s%0d_ev%0d_ch", sid, i), obs_q[i].ch, exp_q[i].ch);
      check($sformatf("s%0d_ev%0d_rise", sid, i), obs_q[i].rise, exp_q[i].rise);
      check($sformatf("s%0d_ev%0d_fall", sid, i), obs_q[i].fall, exp_q[i].fall);
      check($sformatf("s%0d_ev%0d_tmo", sid, i), obs_q[i].tmo, exp_q[i].tmo);
    end
    check($sformatf("s%0d_loop_cnt", sid), loop_cnt, exp_lc);
    check($sformatf("s%0d_timeout_err", sid), timeout_err, exp_tmo);
    check($sformatf("s%0d_end_busy", sid), seq_busy, 0);
    check($sformatf("s%0d_end_en", sid), pwm_en, 0);
    check($sformatf("s%0d_invariants", sid), viol, 0);
    if (is_tbl) begin
      check($sformatf("s%0d_tbl_enables", sid), obs_q.size(), v.exp_en);
      check($sformatf("s%0d_tbl_loop_cnt", sid), loop_cnt, v.exp_lc);
      check($sformatf("s%0d_tbl_tmo", sid), timeout_err, v.exp_tmo);
    end
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_pwm_en"}, pwm_en, 0);
    check({pre, "_cur_ch"}, cur_ch, 0);
    check({pre, "_loop_cnt"}, loop_cnt, 0);
    check({pre, "_seq_busy"}, seq_busy, 0);
    check({pre, "_seq_done"}, seq_done, 0);
    check({pre, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    tbl[0] = mk(4'b1011, 3, 1, 2, 2, 2, 2, 10, 3, 1, 1'b0, 1'b0);
    tbl[1] = mk(4'b0100, 0, 3, 2, 2, 2, 2, 10, 3, 3, 1'b0, 1'b0);
    tbl[2] = mk(4'b0011, 1, 1, 2, 2, 2, Never, 5, 2, 1, 1'b1, 1'b0);
    tbl[3] = mk(4'b0000, 2, 1, 1, 1, 1, 1, 3, 0, 0, 1'b0, 1'b0);
    tbl[4] = mk(4'b1111, 0, 2, 0, 0, 0, 0, 1, 8, 2, 1'b0, 1'b1);
    tbl[5] = mk(4'b1000, 5, 1, 254, 1, 1, 1, 3, 1, 1, 1'b0, 1'b0);
    for (int ch = 0; ch < Nch; ch++) begin
      rise[ch]   = 0;
      rise_v[ch] = 1'b0;
    end

    repeat (3) tick();
    check_zero("reset");
    @(negedge clk_50M);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_seq(tbl[i]);
      finish_seq(tbl[i], i, 1'b1);
    end

    for (int r = 0; r < 8; r++) begin
      v = mk(4'($urandom_range(1, 15)), $urandom_range(0, 6), $urandom_range(1, 3),
             ($urandom_range(0, 9) == 0) ? Never : $urandom_range(0, 12),
             ($urandom_range(0, 9) == 0) ? Never : $urandom_range(0, 12),
             ($urandom_range(0, 9) == 0) ? Never : $urandom_range(0, 12),
             ($urandom_range(0, 9) == 0) ? Never : $urandom_range(0, 12),
             $urandom_range(1, 12), 0, 0, 1'b0, 1'b1);
      start_seq(v);
      finish_seq(v, 10 + r, 1'b0);
    end

    // Endless run on one channel: loop_cnt wraps 255 -> 0, then a stop in RUN.
    noise_en = 1'b0;
    dly_cfg  = '0;
    len_cfg  = 16'd1;
    tick();
    ch_mask    = 4'b0001;
    gap_cycles = 16'd0;
    loop_num   = 8'd0;
    start      = 1'b1;
    lc_t0      = cyc;
    rise_cnt   = 0;
    lc_viol    = 0;
    track_lc   = 1'b1;
    done_q.delete();
    tick();
    start = 1'b0;
    n = 0;
    while (rise_cnt < 258 && n < 1500) begin
      tick();
      n++;
    end
    check("wrap_rises", rise_cnt, 258);
    check("wrap_seq", lc_viol, 0);
    len_cfg = 16'd1000;
    repeat (5) tick();
    check("run_en", pwm_en, 4'b0001);
    start   = 1'b1;
    ch_mask = 4'b1111;
    tick();
    start = 1'b0;
    tick();
    check("ign_start_en", pwm_en, 4'b0001);
    check("ign_start_lc", loop_cnt, 1);
    check("ign_start_busy", seq_busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_en", pwm_en, 0);
    check("stop_busy", seq_busy, 0);
    check("stop_done", seq_done, 0);
    check("stop_lc", loop_cnt, 1);
    repeat (5) tick();
    check("stop_no_done", done_q.size(), 0);
    check("stop_en_after", pwm_en, 0);
    track_lc = 1'b0;

    // start and stop together in IDLE: nothing is accepted.
    ch_mask  = 4'b0001;
    loop_num = 8'd1;
    start    = 1'b1;
    stop     = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", seq_busy, 0);
    check("ss_en", pwm_en, 0);
    check("ss_done", seq_done, 0);
    check("ss_lc", loop_cnt, 1);

    // Asynchronous reset while a channel is in RUN.
    start_seq(tbl[0]);
    while (cyc < exp_q[0].rise + 5) tick();
    #3 rst_n = 1'b0;
    #1 check_zero("rst_run");
    repeat (2) tick();
    @(negedge clk_50M);
    rst_n = 1'b1;
    start_seq(tbl[0]);
    finish_seq(tbl[0], 20, 1'b1);

    // Asynchronous reset during the gap after the second channel.
    start_seq(tbl[0]);
    while (cyc < exp_q[1].fall + 1) tick();
    #3 rst_n = 1'b0;
    #1 check_zero("rst_gap");
    repeat (2) tick();
    @(negedge clk_50M);
    rst_n = 1'b1;
    start_seq(tbl[0]);
    finish_seq(tbl[0], 21, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
